// File: rtl/ascii_hex_accumulator.sv
// ascii_hex_accumulator: accumulates a stream of ASCII hex digits MSB-first
// into a NUM_DIGITS-nibble working value. It supports backspace, commits on a
// terminator byte with a one-cycle valid pulse, and reports overflow and
// illegal characters.
module ascii_hex_accumulator #(
    parameter int         NUM_DIGITS   = 4,
    parameter bit         ACCEPT_LOWER = 1'b1,
    parameter logic [7:0] TERM_CHAR    = 8'h0D,
    parameter logic [7:0] BS_CHAR      = 8'h08,
    localparam int        CW           = $clog2(NUM_DIGITS + 1),
    localparam int        W            = 4 * NUM_DIGITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    char_in,
    input  logic          char_valid,
    output logic          char_ready,
    input  logic          clear,
    output logic [W-1:0]  work_value,
    output logic [CW-1:0] digit_count,
    output logic [W-1:0]  value_out,
    output logic          value_valid,
    output logic          overflow,
    output logic          err
);

    typedef enum logic {ACCUM = 1'b0, COMMIT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic       started;      // low until the first edge after reset release
    logic       accept;
    logic       is_digit, is_bs, is_term;
    logic [3:0] nib;
    logic       has_digits, full, do_commit;

    assign accept     = char_valid & char_ready;
    assign has_digits = (digit_count != '0);
    assign full       = (digit_count == CW'(NUM_DIGITS));
    // A terminator only commits when there is something to commit and clear
    // is not discarding the character in the same cycle.
    assign do_commit  = accept & ~clear & is_term & has_digits;

    // Classify the incoming byte and decode its nibble value
    always_comb begin
        is_digit = 1'b0;
        nib      = 4'h0;
        is_term  = (char_in == TERM_CHAR);
        is_bs    = (char_in == BS_CHAR);
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            is_digit = 1'b1;
            nib      = char_in[3:0];
        end else if (char_in >= 8'h41 && char_in <= 8'h46) begin
            is_digit = 1'b1;
            nib      = char_in[3:0] + 4'd9;
        end else if (ACCEPT_LOWER && char_in >= 8'h61 && char_in <= 8'h66) begin
            is_digit = 1'b1;
            nib      = char_in[3:0] + 4'd9;
        end
    end

    // State register; char_ready is held off until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    // Next-state: COMMIT lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (do_commit) state_nxt = COMMIT;
            COMMIT:  state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // FSM outputs
    always_comb begin
        char_ready  = started & (state == ACCUM);
        value_valid = (state == COMMIT);
    end

    // Working value, digit count, overflow, committed value and err pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_value  <= '0;
            digit_count <= '0;
            value_out   <= '0;
            overflow    <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clear) begin
                // Any character accepted this cycle is consumed and dropped
                work_value  <= '0;
                digit_count <= '0;
                overflow    <= 1'b0;
            end else if (accept) begin
                if (is_term) begin
                    if (has_digits) begin
                        value_out   <= work_value;
                        work_value  <= '0;
                        digit_count <= '0;
                        overflow    <= 1'b0;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (is_bs) begin
                    if (has_digits) begin
                        work_value  <= work_value >> 4;
                        digit_count <= digit_count - CW'(1);
                    end
                end else if (is_digit) begin
                    // When full, the shift drops the top nibble
                    work_value <= (work_value << 4) | W'(nib);
                    if (full) overflow    <= 1'b1;
                    else      digit_count <= digit_count + CW'(1);
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ascii_hex_accumulator.sv
// Directed bench for ascii_hex_accumulator. Expected committed values are
// queued when the terminator is driven and compared when value_valid appears.
// A second instance with ACCEPT_LOWER=0 shares the stimulus. Its outputs are
// checked only after the common reset that aligns both instances.
module tb_ascii_hex_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        clear;

    logic        char_ready, value_valid, overflow, err;
    logic [15:0] work_value, value_out;
    logic [2:0]  digit_count;

    logic        nl_char_ready, nl_value_valid, nl_overflow, nl_err;
    logic [15:0] nl_work_value, nl_value_out;
    logic [2:0]  nl_digit_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    ascii_hex_accumulator #(.NUM_DIGITS(4), .ACCEPT_LOWER(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .clear(clear), .work_value(work_value),
        .digit_count(digit_count), .value_out(value_out),
        .value_valid(value_valid), .overflow(overflow), .err(err)
    );

    ascii_hex_accumulator #(.NUM_DIGITS(4), .ACCEPT_LOWER(1'b0)) dut_nl (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .char_ready(nl_char_ready), .clear(clear), .work_value(nl_work_value),
        .digit_count(nl_digit_count), .value_out(nl_value_out),
        .value_valid(nl_value_valid), .overflow(nl_overflow), .err(nl_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one accepted handshake. The task waits (bounded)
    // for char_ready before presenting the byte.
    task automatic send(input logic [7:0] c);
        int n = 0;
        while (!char_ready && n < 8) begin
            step();
            n++;
        end
        if (!char_ready) chk("ready_timeout", 32'(char_ready), 32'd1);
        char_in    = c;
        char_valid = 1'b1;
        step();
        char_valid = 1'b0;
        char_in    = 8'h00;
    endtask

    // Send CR expecting a commit: queue the value, then pop and compare on valid
    task automatic commit(input string tag, input logic [15:0] exp);
        logic [15:0] e;
        exp_q.push_back(exp);
        send(8'h0D);
        chk({tag, "_valid"}, 32'(value_valid), 32'd1);
        chk({tag, "_ready_low"}, 32'(char_ready), 32'd0);
        chk({tag, "_no_err"}, 32'(err), 32'd0);
        if (value_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_value"}, 32'(value_out), 32'(e));
        end else begin
            chk({tag, "_value_missing"}, 32'(value_valid), 32'd1);
        end
        chk({tag, "_count0"}, 32'(digit_count), 32'd0);
        chk({tag, "_work0"}, 32'(work_value), 32'd0);
        step();
        chk({tag, "_pulse_end"}, 32'(value_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(char_ready), 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; char_in = 8'h00; char_valid = 1'b0; clear = 1'b0;
        #12;
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_work", 32'(work_value), 32'd0);
        chk("rst_valid", 32'(value_valid), 32'd0);
        chk("rst_vout", 32'(value_out), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(char_ready), 32'd1);

        // 1: "1A3f" CR
        send("1"); chk("t1_w1", 32'(work_value), 32'h0001);
        send("A"); chk("t1_w2", 32'(work_value), 32'h001A);
        send("3");
        send("f"); chk("t1_w4", 32'(work_value), 32'h1A3F);
        chk("t1_cnt4", 32'(digit_count), 32'd4);
        commit("t1", 16'h1A3F);

        // 2: "12345" CR -> overflow, top nibble dropped
        send("1"); send("2"); send("3"); send("4");
        chk("t2_no_ovf", 32'(overflow), 32'd0);
        send("5");
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_cnt", 32'(digit_count), 32'd4);
        chk("t2_work", 32'(work_value), 32'h2345);
        commit("t2", 16'h2345);
        chk("t2_ovf_cleared", 32'(overflow), 32'd0);

        // 3: "AB" BS "C" CR
        send("A");   chk("t3_w1", 32'(work_value), 32'h000A);
        send("B");   chk("t3_w2", 32'(work_value), 32'h00AB);
        send(8'h08); chk("t3_w3", 32'(work_value), 32'h000A);
        chk("t3_cnt_bs", 32'(digit_count), 32'd1);
        send("C");   chk("t3_w4", 32'(work_value), 32'h00AC);
        commit("t3", 16'h00AC);
        send(8'h08); // backspace when empty: no change, no err
        chk("t3_bs_empty_err", 32'(err), 32'd0);
        chk("t3_bs_empty_cnt", 32'(digit_count), 32'd0);

        // 4: illegal char, then empty commit
        send("G");
        chk("t4_err1", 32'(err), 32'd1);
        chk("t4_work", 32'(work_value), 32'h0000);
        step();
        chk("t4_err_pulse", 32'(err), 32'd0);
        send(8'h0D);
        chk("t4_err2", 32'(err), 32'd1);
        chk("t4_no_valid", 32'(value_valid), 32'd0);
        chk("t4_vout", 32'(value_out), 32'h00AC);
        chk("t4_ready", 32'(char_ready), 32'd1);

        // 5: "7", then clear together with an accepted "8"
        send("7"); chk("t5_w", 32'(work_value), 32'h0007);
        clear = 1'b1;
        send("8");
        clear = 1'b0;
        chk("t5_work", 32'(work_value), 32'h0000);
        chk("t5_cnt", 32'(digit_count), 32'd0);
        chk("t5_vout", 32'(value_out), 32'h00AC);
        chk("t5_err", 32'(err), 32'd0);
        // clear also drops sticky overflow
        send("1"); send("2"); send("3"); send("4"); send("5");
        chk("t5_ovf_set", 32'(overflow), 32'd1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("t5_ovf_clr", 32'(overflow), 32'd0);

        // 6: async reset mid-entry
        send("5"); chk("t6_w", 32'(work_value), 32'h0005);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_work", 32'(work_value), 32'd0);
        chk("t6_rst_cnt", 32'(digit_count), 32'd0);
        chk("t6_rst_vout", 32'(value_out), 32'd0);
        chk("t6_rst_ready", 32'(char_ready), 32'd0);
        #2 rst_n = 1'b1;
        step();
        send("9");
        commit("t6", 16'h0009);
        chk("t6_nl_vout", 32'(nl_value_out), 32'h0009);

        // lowercase rejected only when ACCEPT_LOWER=0
        send("f");
        chk("t6_lc_work", 32'(work_value), 32'h000F);
        chk("t6_lc_err", 32'(err), 32'd0);
        chk("t6_nl_err", 32'(nl_err), 32'd1);
        chk("t6_nl_work", 32'(nl_work_value), 32'h0000);
        send("F");
        chk("t6_nl_upper", 32'(nl_work_value), 32'h000F);
        chk("t6_nl_upper_err", 32'(nl_err), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
